// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution frame sequencer:
//   state_t    - sequencer FSM states
//   DEF_IMG_W / DEF_IMG_H - default image geometry
//   PAD_W / PAD_H         - padded slot grid for the default geometry
//   pad_dim()   - padded extent of one image dimension (one pad slot per side)
//   cnt_width() - bits needed to index 0..n-1 (never less than 1)
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    BODY,
    BOT,
    DRAIN
  } state_t;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int PAD_W     = DEF_IMG_W + 2;
  localparam int PAD_H     = DEF_IMG_H + 2;

  function automatic int pad_dim(input int n);
    return n + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_slot_counter.sv
// -----------------------------------------------------------------------------
// conv_slot_counter
// Column/row position in the padded slot grid. Both counters move only on
// advance (an issued slot); the column wraps COLS-1 -> 0 and bumps the row,
// and the row wraps ROWS-1 -> 0 so the pair sits at (0,0) after a full frame.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   advance    - a slot was issued this cycle
//   pc, pr     - current column / row of the next slot to issue
//   col_last   - pc is the right pad column
//   row_last   - pr is the bottom pad row
// -----------------------------------------------------------------------------
module conv_slot_counter
  import conv_pkg::*;
#(
  parameter int COLS = PAD_W,
  parameter int ROWS = PAD_H,
  parameter int CW   = cnt_width(COLS),
  parameter int RW   = cnt_width(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] pc,
  output logic [RW-1:0] pr,
  output logic          col_last,
  output logic          row_last
);

  assign col_last = (pc == CW'(COLS - 1));
  assign row_last = (pr == RW'(ROWS - 1));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      pr <= '0;
    end else if (advance) begin
      if (col_last) begin
        pc <= '0;
        pr <= row_last ? '0 : pr + RW'(1);
      end else begin
        pc <= pc + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl
// Frame sequencer in front of the 3x3 line buffer. Walks the padded slot grid
// (IMG_H+2) x (IMG_W+2): a zero top row, the image rows framed by zero pad
// columns, and a zero bottom row. Pixels come from a valid/ready stream; pad
// slots never wait for upstream. Each issued slot whose 3x3 neighbourhood is
// complete raises win_valid one cycle later with the window centre
// coordinates; a pending window that is not accepted freezes the stream.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - frame start pulse (ignored unless idle)
//   busy, done           - frame in progress / last window accepted pulse
//   s_data/s_valid/s_ready - upstream pixel stream
//   lb_data, lb_valid    - one padded slot to the line buffer
//   lb_out_valid         - lb_valid delayed one cycle (line buffer output strobe)
//   win_valid/win_ready  - window handshake to the convolution stage
//   win_row, win_col     - window centre coordinates
// -----------------------------------------------------------------------------
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int PADDING = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [7:0]                  lb_data,
  output logic                        lb_valid,
  output logic                        lb_out_valid,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [cnt_width(IMG_H)-1:0] win_row,
  output logic [cnt_width(IMG_W)-1:0] win_col
);

  localparam int COLS = pad_dim(IMG_W);
  localparam int ROWS = pad_dim(IMG_H);
  localparam int CW   = cnt_width(COLS);
  localparam int RW   = cnt_width(ROWS);
  localparam int WRW  = cnt_width(IMG_H);
  localparam int WCW  = cnt_width(IMG_W);

  if (PADDING != 1) begin : g_bad_padding
    $error("conv_window_ctrl: only PADDING=1 is supported");
  end

  state_t          state;
  logic [CW-1:0]   pc;
  logic [RW-1:0]   pr;
  logic            col_last;
  logic            row_last;
  logic            stall;
  logic            in_frame;
  logic            data_slot;
  logic            issue;
  logic            qualify;

  conv_slot_counter #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (issue),
    .pc       (pc),
    .pr       (pr),
    .col_last (col_last),
    .row_last (row_last)
  );

  // A pending window that the consumer has not taken blocks all issue, so the
  // line buffer outputs stay aligned with the window being presented.
  assign stall     = win_valid && !win_ready;
  assign in_frame  = (state == TOP) || (state == BODY) || (state == BOT);
  // Image pixels occupy the interior columns of the body rows only.
  assign data_slot = (state == BODY) && (pc != '0) && !col_last;
  assign issue     = in_frame && !stall && (!data_slot || s_valid);
  // The slot issued now completes the window centred one row up, one column left.
  assign qualify   = (pr >= RW'(2)) && (pc >= CW'(2));

  assign busy     = (state != IDLE);
  assign s_ready  = data_slot && !stall;
  assign lb_valid = issue;
  assign lb_data  = data_slot ? s_data : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      done         <= 1'b0;
      lb_out_valid <= 1'b0;
      win_valid    <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      done         <= 1'b0;
      lb_out_valid <= issue;

      // A new qualifying slot can only issue when the pending window is being
      // accepted (or none is pending), so overwriting the coordinates is safe.
      if (issue && qualify) begin
        win_valid <= 1'b1;
        win_row   <= WRW'(pr - RW'(2));
        win_col   <= WCW'(pc - CW'(2));
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end

      case (state)
        IDLE:  if (start) state <= TOP;
        TOP:   if (issue && col_last) state <= BODY;
        BODY:  if (issue && col_last && (pr == RW'(IMG_H))) state <= BOT;
        BOT:   if (issue && col_last && row_last) state <= DRAIN;
        DRAIN: begin
          // Only the final window can be pending here.
          if (win_valid && win_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_window_ctrl
// Self-checking bench for conv_window_ctrl with a 4x3 image. A table of frame
// scenarios (pixel pattern, upstream bubbles, downstream stalls, stray start
// pulses) with expected slot/window counts and start-to-done latency is run
// back to back, followed by a mid-frame reset and randomized frames. A
// cycle monitor keeps a slot-index model of the padded raster and checks every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_conv_window_ctrl;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int COLS  = W + 2;
  localparam int ROWS  = H + 2;
  localparam int NSLOT = COLS * ROWS;
  localparam int NPIX  = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic       busy, done, s_ready, lb_valid, lb_out_valid, win_valid;
  logic [7:0] lb_data;
  logic [1:0] win_row, win_col;

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .PADDING(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .lb_data      (lb_data),
    .lb_valid     (lb_valid),
    .lb_out_valid (lb_out_valid),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .win_row      (win_row),
    .win_col      (win_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the padded raster as a flat slot index k.
  // ---------------------------------------------------------------------------
  logic [7:0] pix [NPIX];
  logic [7:0] cap [NSLOT];

  function automatic bit is_data(input int k);
    int r, c;
    r = k / COLS;
    c = k % COLS;
    return (r >= 1) && (r <= H) && (c >= 1) && (c <= W);
  endfunction

  function automatic logic [7:0] exp_slot(input int k);
    if (!is_data(k)) return 8'h00;
    return pix[(k / COLS - 1) * W + (k % COLS - 1)];
  endfunction

  bit mon_en = 1'b0;
  bit issuing, pend, exp_done, exp_busy, prev_lbv;
  bit m_stall, m_data, m_lbv, m_acc;
  int k, pend_r, pend_c, n_slots, n_wins;

  always @(negedge clk) begin
    if (!mon_en) begin
      issuing  = 1'b0;
      pend     = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      prev_lbv = 1'b0;
      k        = 0;
      pend_r   = 0;
      pend_c   = 0;
    end else begin
      m_stall = pend && !win_ready;
      m_data  = issuing && is_data(k);
      m_lbv   = issuing && !m_stall && (!m_data || s_valid);
      m_acc   = pend && win_ready;

      check($sformatf("lb_valid@%0d", cyc), 32'(lb_valid), 32'(m_lbv));
      check($sformatf("s_ready@%0d", cyc), 32'(s_ready), 32'(m_data && !m_stall));
      check($sformatf("win_valid@%0d", cyc), 32'(win_valid), 32'(pend));
      if (pend) begin
        check($sformatf("win_row@%0d", cyc), 32'(win_row), 32'(pend_r));
        check($sformatf("win_col@%0d", cyc), 32'(win_col), 32'(pend_c));
      end
      check($sformatf("done@%0d", cyc), 32'(done), 32'(exp_done));
      check($sformatf("busy@%0d", cyc), 32'(busy), 32'(exp_busy));
      check($sformatf("lb_out_valid@%0d", cyc), 32'(lb_out_valid), 32'(prev_lbv));
      if (m_lbv) begin
        check($sformatf("lb_data_slot%0d@%0d", k, cyc), 32'(lb_data), 32'(exp_slot(k)));
        cap[k] = lb_data;
      end

      // Expectations for the next cycle.
      exp_done = m_acc && (pend_r == H - 1) && (pend_c == W - 1);
      if (m_acc) n_wins++;
      if (m_lbv && (k / COLS >= 2) && (k % COLS >= 2)) begin
        pend   = 1'b1;
        pend_r = k / COLS - 2;
        pend_c = k % COLS - 2;
      end else if (m_acc) begin
        pend = 1'b0;
      end
      if (m_lbv) begin
        n_slots++;
        k++;
        if (k == NSLOT) issuing = 1'b0;
      end
      if (exp_done) begin
        exp_busy = 1'b0;
      end else if (!exp_busy && start) begin
        exp_busy = 1'b1;
        issuing  = 1'b1;
        k        = 0;
        n_slots  = 0;
        n_wins   = 0;
      end
      prev_lbv = m_lbv;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame scenarios
  // ---------------------------------------------------------------------------
  typedef struct {
    int pat;          // 0: 1..N, 1: all 255, 2: random
    int bub_at;       // pixels accepted before the bubble (-1: none)
    int bub_len;
    int stl_r;        // window held back by win_ready low (-1: none)
    int stl_c;
    int stl_len;
    int p_sv;         // s_valid probability in percent
    int p_wr;         // win_ready probability in percent
    int restart_at;   // cycle offset of a stray start pulse (-1: none)
    int exp_slots;
    int exp_windows;
    int exp_latency;  // start cycle to done cycle (-1: not checked)
  } vec_t;

  task automatic run_frame(input int fidx, input vec_t v);
    int  sent, bub, stl, t0, lat;
    bit  got;
    for (int i = 0; i < NPIX; i++) begin
      case (v.pat)
        0:       pix[i] = 8'(i + 1);
        1:       pix[i] = 8'd255;
        default: pix[i] = 8'($urandom_range(255));
      endcase
    end
    sent = 0; bub = 0; stl = 0; lat = 0; got = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (sent == v.bub_at && bub < v.bub_len) begin
        s_valid = 1'b0;
        bub++;
      end else begin
        s_valid = ($urandom_range(99) < v.p_sv);
      end
      s_data = (sent < NPIX) ? pix[sent] : 8'h00;
      if (win_valid && int'(win_row) == v.stl_r && int'(win_col) == v.stl_c && stl < v.stl_len) begin
        win_ready = 1'b0;
        stl++;
      end else begin
        win_ready = ($urandom_range(99) < v.p_wr);
      end
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
      start = (i + 1 == v.restart_at);
    end
    #1;
    check($sformatf("frame%0d_done_seen", fidx), 32'(got), 32'd1);
    check($sformatf("frame%0d_slots", fidx), 32'(n_slots), 32'(v.exp_slots));
    check($sformatf("frame%0d_windows", fidx), 32'(n_wins), 32'(v.exp_windows));
    if (v.exp_latency >= 0)
      check($sformatf("frame%0d_latency", fidx), 32'(lat), 32'(v.exp_latency));
    if (v.pat == 1) begin
      // Line buffer rows seen by window (0,0): top pad row, then two image rows
      // framed by the left pad column.
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          check($sformatf("frame%0d_win00_r%0d_c%0d", fidx, r, c),
                32'(cap[r * COLS + c]), (r == 0 || c == 0) ? 32'd0 : 32'd255);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_lb_valid"}, 32'(lb_valid), 32'd0);
    check({tag, "_lb_out_valid"}, 32'(lb_out_valid), 32'd0);
    check({tag, "_win_valid"}, 32'(win_valid), 32'd0);
    check({tag, "_lb_data"}, 32'(lb_data), 32'd0);
    check({tag, "_win_row"}, 32'(win_row), 32'd0);
    check({tag, "_win_col"}, 32'(win_col), 32'd0);
  endtask

  vec_t tbl [5];
  vec_t rv;

  initial begin
    //           pat bub_at len stl_r stl_c len p_sv p_wr restart slots wins lat
    tbl[0] = '{0, -1, 0, -1, -1, 0, 100, 100, -1, NSLOT, NPIX, 32};  // nominal
    tbl[1] = '{0,  5, 3, -1, -1, 0, 100, 100, -1, NSLOT, NPIX, 35};  // bubble at pixel 6
    tbl[2] = '{0, -1, 0,  1,  1, 5, 100, 100, -1, NSLOT, NPIX, 37};  // stall on (1,1)
    tbl[3] = '{0, -1, 0, -1, -1, 0, 100, 100, 10, NSLOT, NPIX, 32};  // start while busy
    tbl[4] = '{1, -1, 0, -1, -1, 0, 100, 100, -1, NSLOT, NPIX, 32};  // all 255

    #12;
    check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

    foreach (tbl[i]) run_frame(i, tbl[i]);

    // Reset in the middle of the body rows with a window pending.
    @(posedge clk); #1;
    mon_en    = 1'b0;
    start     = 1'b1;
    s_valid   = 1'b1;
    win_ready = 1'b1;
    s_data    = 8'h5a;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_win_valid", 32'(win_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    run_frame(10, tbl[0]);

    for (int i = 0; i < 6; i++) begin
      rv = '{2, -1, 0, -1, -1, 0, 75, 60, -1, NSLOT, NPIX, -1};
      run_frame(20 + i, rv);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Frame sequencer in front of the 3x3 line buffer. It accepts a raster pixel stream over a valid/ready handshake and feeds the line buffer one slot per issue. Each frame it inserts one zero top-padding row, the left/right padding slots of every row, and one zero bottom-padding row. It emits window-valid strobes with the window coordinates to the convolution stage and honours downstream backpressure. It sits between the pixel source and the line buffer; the line buffer's row outputs and this block's strobes go to the MAC array.

## Interface
Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PADDING, 1, padding width; only 1 is supported, other values are a compile-time error

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low; shared with the line buffer
- start  in  1  frame start pulse; ignored unless the FSM is in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last window of a frame is accepted
- s_data  in  8  upstream pixel
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  upstream pixel accepted when s_valid && s_ready
- lb_data  out  8  line buffer in_data
- lb_valid  out  1  line buffer in_valid; one padded slot per cycle
- lb_out_valid  out  1  lb_valid delayed by one cycle; the consumer shifts its 3-column window register on this strobe
- win_valid  out  1  the current line buffer outputs complete a window
- win_ready  in  1  consumer accepts the window
- win_row  out  clog2(IMG_H)  row of the window centre
- win_col  out  clog2(IMG_W)  column of the window centre

## Operation
- Padded slot grid: row index pr runs 0..IMG_H+1; column index pc runs 0..IMG_W+1.
  - pr=0 is the top pad row; pr=IMG_H+1 is the bottom pad row.
  - pc=0 and pc=IMG_W+1 are the column pad slots.
- FSM states:
  - IDLE: start -> TOP.
  - TOP: issues pr=0, all zeros. After its last slot -> BODY.
  - BODY: issues pr=1..IMG_H. After the slot (pr=IMG_H, pc=IMG_W+1) -> BOT.
  - BOT: issues pr=IMG_H+1, all zeros. After its last slot -> DRAIN.
  - DRAIN: waits for the final window to be accepted, then pulses done and goes to IDLE.
- Stall condition: stall = win_valid && !win_ready.
- Slot issue rules (lb_valid):
  - Pad slot: issued whenever the FSM is in TOP, BODY or BOT and there is no stall.
  - BODY data slot (pc in 1..IMG_W): issued only when s_valid && !stall.
  - s_ready = BODY && pc in 1..IMG_W && !stall.
- lb_data = s_data on BODY data slots, otherwise 0.
- pc/pr advance only on an issued slot. pc wraps IMG_W+1 -> 0 and then increments pr. This keeps the line buffer's internal column counter aligned, because both counters reset together and advance on the same in_valid.
- Stale line buffer contents from the previous frame never reach a valid window. The first valid window needs pr>=2; by then buf2 holds the zeros written during TOP.
- Window qualification for an issued slot: pr in 2..IMG_H+1 and pc in 2..IMG_W+1.
  - Set win_valid in the next cycle, with win_row=pr-2 and win_col=pc-2.
  - win_valid is sticky until win_valid && win_ready. Acceptance and a new qualifying issue in the same cycle keep it high with the new coordinates.
- Reset values: FSM=IDLE, pc=pr=0, and busy, done, s_ready, lb_valid, lb_out_valid, win_valid all 0; lb_data, win_row, win_col all 0.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is abandoned and no done pulse is generated.

## Timing
- start at cycle t: TOP issues its first slot at t+1. Without upstream bubbles or stalls, lb_valid is continuous for (IMG_H+2)*(IMG_W+2) cycles.
- Issue-to-window latency is 1 cycle, matching the line buffer's registered outputs. lb_out_valid and the first assertion of win_valid coincide.
- done pulses in the cycle after the acceptance of window (IMG_H-1, IMG_W-1).
- An upstream bubble inserts one idle cycle with no lb_valid; pad slots never wait on s_valid.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, TOP, BODY, BOT, DRAIN)
  - localparams PAD_W=IMG_W+2 and PAD_H=IMG_H+2
  - a function giving the counter widths
- One sub-module: conv_slot_counter, the pc/pr counter pair with an advance input, wrap, and last-slot flags. The FSM, handshake and window logic stay in the top level.

## Test plan
- IMG_W=4, IMG_H=3, pixels 1..12, s_valid always 1, win_ready always 1:
  - 30 consecutive lb_valid cycles.
  - lb_data is 0 on all pad slots and 1..12 in order on data slots.
  - 12 windows in raster order, (0,0) through (2,3).
  - done pulses once, one cycle after window (2,3).
- Same configuration with s_valid low for 3 cycles at pixel 6: three lb_valid gaps with pad slots unaffected; the window sequence is unchanged.
- win_ready low for 5 cycles while window (1,1) is valid: win_valid, win_row=1 and win_col=1 held; lb_valid and s_ready low; the stream resumes in the cycle win_ready rises.
- start pulsed while busy: ignored, with no change to the slot sequence. Two back-to-back frames produce identical window sequences with no stale data.
- rst_n asserted mid-BODY: all outputs return to reset values asynchronously; a new frame after reset completes correctly.
- Constant all-255 image, checked against the line buffer outputs at window (0,0): row0=0,0,0; row1=0,255,255; row2=0,255,255.
